// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the PC fetch unit: next-PC select, FSM states and default reset PC.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JREG   = 2'b11
  } npc_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam int          DEF_IM_WORDS = 1024;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Redirect-request and fetch-status bundle between the core and the PC fetch unit.
interface pc_fetch_if;
  import pc_fetch_unit_pkg::*;

  logic        stall;
  npc_sel_e    npc_sel;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [9:0]  im_addr;
  logic [31:0] fetch_cnt;
  logic        addr_err;

  modport master (
    output stall, npc_sel, br_taken, imm16, instr_index, jr_target,
    input  pc, pc_plus4, im_addr, fetch_cnt, addr_err
  );

  modport slave (
    input  stall, npc_sel, br_taken, imm16, instr_index, jr_target,
    output pc, pc_plus4, im_addr, fetch_cnt, addr_err
  );
endinterface

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC generator: sequential, PC-relative branch, j/jal region jump, jr.
module npc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  input  npc_sel_e    i_npc_sel,
  input  logic        i_br_taken,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_instr_index,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_npc
);

  logic [31:0] w_br_off;

  assign o_pc_plus4 = i_pc + 32'd4;
  // Branch offset counts words from the delay-free pc+4.
  assign w_br_off   = {{14{i_imm16[15]}}, i_imm16, 2'b00};

  always_comb begin
    o_npc = o_pc_plus4;
    case (i_npc_sel)
      NPC_SEQ:    o_npc = o_pc_plus4;
      NPC_BRANCH: o_npc = i_br_taken ? (o_pc_plus4 + w_br_off) : o_pc_plus4;
      NPC_JUMP:   o_npc = {o_pc_plus4[31:28], i_instr_index, 2'b00};
      NPC_JREG:   o_npc = i_jr_target;
      default:    o_npc = o_pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch counter and RUN/HALT control. Define ADDR_CHECK_EN to enable the
// fetch-window fault check (sticky addr_err, halt until reset); otherwise npc always loads.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          IM_WORDS = DEF_IM_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  pc_fetch_if.slave   bus
);

`ifdef ADDR_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  // 33-bit window end so RESET_PC near the top of the map cannot wrap the bound.
  localparam logic [32:0] WIN_END = {1'b0, RESET_PC} + (33'(IM_WORDS) * 33'd4);

  logic [31:0] r_pc;
  logic [31:0] r_fetch_cnt;
  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] w_npc;
  logic [31:0] w_pc_plus4;
  logic        w_bad;
  logic        w_fault;
  logic        w_load;

  npc_calc u_npc_calc (
    .i_pc          (r_pc),
    .i_npc_sel     (bus.npc_sel),
    .i_br_taken    (bus.br_taken),
    .i_imm16       (bus.imm16),
    .i_instr_index (bus.instr_index),
    .i_jr_target   (bus.jr_target),
    .o_pc_plus4    (w_pc_plus4),
    .o_npc         (w_npc)
  );

  assign w_bad   = (w_npc[1:0] != 2'b00) || (w_npc < RESET_PC) || ({1'b0, w_npc} >= WIN_END);
  assign w_fault = CHECK && w_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!bus.stall) begin
          if (w_fault) w_state_nxt = ST_HALT;
          else         w_load      = 1'b1;
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_fetch_cnt <= 32'd0;
    end else if (w_load) begin
      r_pc        <= w_npc;
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

`ifdef ADDR_CHECK_EN
  logic r_addr_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               r_addr_err <= 1'b0;
    else if (r_state == ST_RUN && w_state_nxt == ST_HALT) r_addr_err <= 1'b1;
  end

  assign bus.addr_err = r_addr_err;
`else
  assign bus.addr_err = 1'b0;
`endif

  assign bus.pc        = r_pc;
  assign bus.pc_plus4  = w_pc_plus4;
  assign bus.im_addr   = r_pc[11:2];
  assign bus.fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed table, hand sequences for reset/fault/wrap, random vs model.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

`ifdef ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_if bus();

  pc_fetch_unit #(.RESET_PC(32'h0000_3000), .IM_WORDS(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_err;
  bit          m_halt;

  typedef struct {
    bit          stall;
    npc_sel_e    sel;
    bit          br;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jr;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_npc(input logic [31:0] pc, input npc_sel_e sel, input bit br,
                                          input logic [15:0] imm, input logic [25:0] idx,
                                          input logic [31:0] jr);
    int off;
    off = int'($signed(imm)) * 4;
    case (sel)
      NPC_BRANCH: return br ? pc + 32'd4 + 32'(off) : pc + 32'd4;
      NPC_JUMP:   return ((pc + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4);
      NPC_JREG:   return jr;
      default:    return pc + 32'd4;
    endcase
  endfunction

  function automatic bit out_of_window(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a >= 32'h3000 + 4 * 1024);
  endfunction

  task automatic drive(input bit st, input npc_sel_e sel, input bit br, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] jr);
    bus.stall       = st;
    bus.npc_sel     = sel;
    bus.br_taken    = br;
    bus.imm16       = imm;
    bus.instr_index = idx;
    bus.jr_target   = jr;
  endtask

  // Advance the reference by one clock using the current inputs, then clock the DUT.
  task automatic step();
    logic [31:0] n;
    if (!m_halt && !bus.stall) begin
      n = ref_npc(m_pc, bus.npc_sel, bus.br_taken, bus.imm16, bus.instr_index, bus.jr_target);
      if (CHK && out_of_window(n)) begin
        m_err  = 1'b1;
        m_halt = 1'b1;
      end else begin
        m_pc  = n;
        m_cnt = m_cnt + 32'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ia;
    ia = {22'd0, m_pc[11:2]};
    check({tag, ".pc"},       bus.pc,              m_pc);
    check({tag, ".pc_plus4"}, bus.pc_plus4,        m_pc + 32'd4);
    check({tag, ".im_addr"},  {22'd0, bus.im_addr}, ia);
    check({tag, ".cnt"},      bus.fetch_cnt,       m_cnt);
    check({tag, ".err"},      {31'd0, bus.addr_err}, {31'd0, m_err});
  endtask

  // Mid-cycle asynchronous reset: takes effect without waiting for a clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    m_pc = 32'h3000; m_cnt = 0; m_err = 0; m_halt = 0;
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] e;
    logic [31:0] jr;
    logic [15:0] imm;

    drive(1'b0, NPC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
    rst = 1'b1;
    m_pc = 32'h3000; m_cnt = 0; m_err = 0; m_halt = 0;
    #3;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("reset_hold");

    tbl[0]  = '{0, NPC_SEQ,    0, 16'h0000, 26'h0,     32'h0,    32'h3004, 1};
    tbl[1]  = '{0, NPC_SEQ,    0, 16'h0000, 26'h0,     32'h0,    32'h3008, 2};
    tbl[2]  = '{0, NPC_SEQ,    0, 16'h0000, 26'h0,     32'h0,    32'h300C, 3};
    tbl[3]  = '{0, NPC_JREG,   0, 16'h0000, 26'h0,     32'h3008, 32'h3008, 4};
    tbl[4]  = '{0, NPC_BRANCH, 1, 16'hFFFE, 26'h0,     32'h0,    32'h3004, 5};
    tbl[5]  = '{0, NPC_JREG,   0, 16'h0000, 26'h0,     32'h3008, 32'h3008, 6};
    tbl[6]  = '{0, NPC_BRANCH, 0, 16'hFFFE, 26'h0,     32'h0,    32'h300C, 7};
    tbl[7]  = '{0, NPC_JREG,   0, 16'h0000, 26'h0,     32'h3000, 32'h3000, 8};
    tbl[8]  = '{0, NPC_JUMP,   0, 16'h0000, 26'h0C05,  32'h0,    32'h3014, 9};
    tbl[9]  = '{0, NPC_JREG,   0, 16'h0000, 26'h0,     32'h3100, 32'h3100, 10};
    tbl[10] = '{1, NPC_JUMP,   0, 16'h0000, 26'h0C05,  32'h0,    32'h3100, 10};
    tbl[11] = '{1, NPC_JUMP,   0, 16'h0000, 26'h0C05,  32'h0,    32'h3100, 10};
    tbl[12] = '{0, NPC_SEQ,    0, 16'h0000, 26'h0,     32'h0,    32'h3104, 11};
    tbl[13] = '{0, NPC_BRANCH, 1, 16'h0010, 26'h0,     32'h0,    32'h3148, 12};
    tbl[14] = '{1, NPC_JREG,   0, 16'h0000, 26'h0,     32'h3002, 32'h3148, 12};

    prev = 32'h3000;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].stall, tbl[i].sel, tbl[i].br, tbl[i].imm, tbl[i].idx, tbl[i].jr);
      #1;
      check($sformatf("tbl%0d.pc_plus4_pre", i), bus.pc_plus4, prev + 32'd4);
      @(posedge clk); #1;
      e = tbl[i].exp_pc;
      check($sformatf("tbl%0d.pc", i),      bus.pc,               e);
      check($sformatf("tbl%0d.im_addr", i), {22'd0, bus.im_addr}, {22'd0, e[11:2]});
      check($sformatf("tbl%0d.cnt", i),     bus.fetch_cnt,        tbl[i].exp_cnt);
      check($sformatf("tbl%0d.err", i),     {31'd0, bus.addr_err}, 32'd0);
      prev = e;
    end
    m_pc = prev; m_cnt = 32'd12;

    // Reset while pc=0x3010
    drive(1'b0, NPC_JREG, 1'b0, 16'h0, 26'h0, 32'h3010);
    step();
    check("pre_rst.pc", bus.pc, 32'h3010);
    do_reset("midrst");
    check("midrst.pc", bus.pc, 32'h3000);

    // Misaligned jr target
    drive(1'b0, NPC_JREG, 1'b0, 16'h0, 26'h0, 32'h3002);
    step();
    check_all("jr_misalign");
    if (CHK) begin
      check("chk.err", {31'd0, bus.addr_err}, 32'd1);
      check("chk.pc_hold", bus.pc, 32'h3000);
      drive(1'b0, NPC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
      step(); step();
      check_all("halt_seq");
      check("halt.pc", bus.pc, 32'h3000);
      do_reset("halt_rst");
      // Last legal word, then the first word past the window
      drive(1'b0, NPC_JREG, 1'b0, 16'h0, 26'h0, 32'h3FFC);
      step();
      check("win_last.pc", bus.pc, 32'h3FFC);
      drive(1'b0, NPC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
      step();
      check_all("win_end");
      check("win_end.err", {31'd0, bus.addr_err}, 32'd1);
      do_reset("win_rst");
    end else begin
      check("nochk.pc", bus.pc, 32'h3002);
      check("nochk.im_addr", {22'd0, bus.im_addr}, 32'd0);
      drive(1'b0, NPC_JREG, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC);
      step();
      check("wrap.pc_plus4", bus.pc_plus4, 32'd0);
      drive(1'b0, NPC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0);
      step();
      check("wrap.pc", bus.pc, 32'd0);
      drive(1'b0, NPC_BRANCH, 1'b1, 16'h8000, 26'h0, 32'h0);
      step();
      check("br_min.pc", bus.pc, 32'hFFFE_0004);
      check_all("br_min");
      do_reset("nochk_rst");
    end

    // Randomised run against the reference model
    for (int c = 0; c < 400; c++) begin
      if (m_halt && ($urandom % 2 == 0)) do_reset("rnd_rst");
      jr  = ($urandom % 2 == 0) ? 32'h3000 + 4 * $urandom_range(0, 1023) : $urandom;
      imm = ($urandom % 2 == 0) ? 16'($urandom_range(0, 64)) - 16'd32 : 16'($urandom);
      drive($urandom % 4 == 0, npc_sel_e'($urandom % 4), 1'($urandom), imm,
            26'($urandom), jr);
      step();
      check_all($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
